smi_mem_lib_write_burst_arb: RTL

SMI_MEM_LIB_WRITE_BURST_ARB -- requirements
Module: smi_mem_lib_write_burst_arb

---
 rtl/smi_mem_lib_pkg.sv | 12 +
 rtl/smi_mem_lib_rr_arb2.sv | 22 ++
 rtl/smi_mem_lib_write_burst_arb.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/smi_mem_lib_pkg.sv
// Shared types for the smi_mem_lib write-burst arbitration slice: FSM encoding
// and requester count.
package smi_mem_lib_pkg;
    localparam int NumReq = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PARAMS = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } arbState_t;
endpackage

// File: rtl/smi_mem_lib_rr_arb2.sv
// Two-requester grant logic: round-robin against the last granted index, or
// fixed priority with requester 0 highest. Output grant is one-hot (or zero).
module smi_mem_lib_rr_arb2
    import smi_mem_lib_pkg::*;
(
    input  logic [NumReq-1:0] req,
    input  logic              lastGrant,
    input  logic              roundRobin,
    output logic [NumReq-1:0] grant
);
    always_comb begin
        grant = req;
        // Only a tie needs a decision; a single request is granted as-is.
        if (req == 2'b11) begin
            if (roundRobin && !lastGrant) begin
                grant = 2'b10;
            end else begin
                grant = 2'b01;
            end
        end
    end
endmodule

// File: rtl/smi_mem_lib_write_burst_arb.sv
// Shares one segmented 64-bit write burst engine between two requesters; one
// owner holds the engine from parameter acceptance to done delivery.
module smi_mem_lib_write_burst_arb
    import smi_mem_lib_pkg::*;
#(
    parameter int RoundRobin = 1
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        req0ParamsValid,
    input  logic [63:0] req0BurstAddr,
    input  logic [31:0] req0BurstLen,
    input  logic [7:0]  req0BurstOpts,
    output logic        req0ParamsStop,
    input  logic        req0WriteValid,
    input  logic [63:0] req0WriteData,
    output logic        req0WriteStop,
    output logic        req0DoneValid,
    output logic        req0DoneStatusOk,
    input  logic        req0DoneStop,
    input  logic        req1ParamsValid,
    input  logic [63:0] req1BurstAddr,
    input  logic [31:0] req1BurstLen,
    input  logic [7:0]  req1BurstOpts,
    output logic        req1ParamsStop,
    input  logic        req1WriteValid,
    input  logic [63:0] req1WriteData,
    output logic        req1WriteStop,
    output logic        req1DoneValid,
    output logic        req1DoneStatusOk,
    input  logic        req1DoneStop,
    output logic        engParamsValid,
    output logic [63:0] engBurstAddr,
    output logic [31:0] engBurstLen,
    output logic [7:0]  engBurstOpts,
    input  logic        engParamsStop,
    output logic        engWriteValid,
    output logic [63:0] engWriteData,
    input  logic        engWriteStop,
    input  logic        engDoneValid,
    input  logic        engDoneStatusOk,
    output logic        engDoneStop
);
    arbState_t   stateReg, stateNext;
    logic        ownerReg, ownerNext;
    logic        lastGrantReg, lastGrantNext;
    logic [31:0] cntReg, cntNext;
    logic        readyReg;

    logic [NumReq-1:0] paramsValid, writeValid, doneStop;
    logic [NumReq-1:0] paramsStop, writeStop, doneValid, doneStatusOk;
    logic [NumReq-1:0] grant;
    logic [63:0]       burstAddr [NumReq];
    logic [31:0]       burstLen  [NumReq];
    logic [7:0]        burstOpts [NumReq];
    logic [63:0]       writeData [NumReq];
    logic              hsParams, hsBeat, hsDone;

    assign paramsValid  = {req1ParamsValid, req0ParamsValid};
    assign writeValid   = {req1WriteValid, req0WriteValid};
    assign doneStop     = {req1DoneStop, req0DoneStop};
    assign burstAddr[0] = req0BurstAddr;
    assign burstAddr[1] = req1BurstAddr;
    assign burstLen[0]  = req0BurstLen;
    assign burstLen[1]  = req1BurstLen;
    assign burstOpts[0] = req0BurstOpts;
    assign burstOpts[1] = req1BurstOpts;
    assign writeData[0] = req0WriteData;
    assign writeData[1] = req1WriteData;

    smi_mem_lib_rr_arb2 uArb (
        .req        (paramsValid),
        .lastGrant  (lastGrantReg),
        .roundRobin (RoundRobin != 0),
        .grant      (grant)
    );

    // Engine side sees only the owner; valids are gated by state.
    assign engParamsValid = (stateReg == PARAMS) && paramsValid[ownerReg];
    assign engBurstAddr   = burstAddr[ownerReg];
    assign engBurstLen    = burstLen[ownerReg];
    assign engBurstOpts   = burstOpts[ownerReg];
    assign engWriteValid  = (stateReg == STREAM) && (cntReg != 32'd0) && writeValid[ownerReg];
    assign engWriteData   = writeData[ownerReg];
    assign engDoneStop    = (stateReg == DONE) ? doneStop[ownerReg] : 1'b1;

    assign hsParams = engParamsValid && !engParamsStop;
    assign hsBeat   = engWriteValid && !engWriteStop;
    assign hsDone   = (stateReg == DONE) && engDoneValid && !doneStop[ownerReg];

    for (genvar gi = 0; gi < NumReq; gi++) begin : gReq
        logic isOwner;
        assign isOwner            = (ownerReg == 1'(gi));
        assign paramsStop[gi]     = (isOwner && stateReg == PARAMS) ? engParamsStop : 1'b1;
        // Once the count is spent, extra owner beats stay parked on the requester.
        assign writeStop[gi]      = (isOwner && stateReg == STREAM && cntReg != 32'd0)
                                    ? engWriteStop : 1'b1;
        assign doneValid[gi]      = isOwner && (stateReg == DONE) && engDoneValid;
        assign doneStatusOk[gi]   = isOwner && (stateReg == DONE) && engDoneStatusOk;
    end

    assign req0ParamsStop   = paramsStop[0];
    assign req1ParamsStop   = paramsStop[1];
    assign req0WriteStop    = writeStop[0];
    assign req1WriteStop    = writeStop[1];
    assign req0DoneValid    = doneValid[0];
    assign req1DoneValid    = doneValid[1];
    assign req0DoneStatusOk = doneStatusOk[0];
    assign req1DoneStatusOk = doneStatusOk[1];

    always_comb begin
        stateNext     = stateReg;
        ownerNext     = ownerReg;
        lastGrantNext = lastGrantReg;
        cntNext       = cntReg;
        case (stateReg)
            IDLE: begin
                if (readyReg && grant != 2'b00) begin
                    ownerNext = grant[1];
                    stateNext = PARAMS;
                end
            end
            PARAMS: begin
                if (hsParams) begin
                    cntNext   = burstLen[ownerReg];
                    stateNext = (burstLen[ownerReg] == 32'd0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (hsBeat) begin
                    cntNext = cntReg - 32'd1;
                    if (cntReg == 32'd1) stateNext = DONE;
                end
            end
            DONE: begin
                if (hsDone) begin
                    lastGrantNext = ownerReg;
                    stateNext     = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // readyReg holds off arbitration for the first edge after reset release.
    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            stateReg     <= IDLE;
            ownerReg     <= 1'b0;
            lastGrantReg <= 1'b1;
            cntReg       <= 32'd0;
            readyReg     <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            ownerReg     <= ownerNext;
            lastGrantReg <= lastGrantNext;
            cntReg       <= cntNext;
            readyReg     <= 1'b1;
        end
    end
endmodule
